// File: rtl/dram_xfer_ctrl.sv
// DRAM-side transfer engine: loads the input image into local memory on rd_en and
// stores the result back to DRAM on wr_en. Define DRAM_STALL_EN to add dram_ready backpressure.
module dram_xfer_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DRAM_AW  = 18,
    parameter int MEM_AW   = 16,
    parameter int RD_WORDS = 65536,
    parameter int WR_WORDS = 16384,
    parameter int RD_BASE  = 0,
    parameter int WR_BASE  = 65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_en,
    input  logic               wr_en,
`ifdef DRAM_STALL_EN
    input  logic               dram_ready,
`endif
    output logic               rd_done,
    output logic               wr_done,
    output logic               dram_re,
    output logic               dram_we,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [DATA_W-1:0]  dram_wdata,
    input  logic [DATA_W-1:0]  dram_rdata,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int MAX_WORDS = (RD_WORDS > WR_WORDS) ? RD_WORDS : WR_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(RD_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(WR_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, RD_XFER, RD_DRAIN, RD_DONE, WR_XFER, WR_DRAIN, WR_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              aborting;
    logic [DATA_W-1:0] wr_word;

    // accept: the DRAM request on the bus this cycle (if any) is taken at the coming edge.
`ifdef DRAM_STALL_EN
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;

    assign accept  = dram_ready || !(dram_re || dram_we);
    assign wr_word = hold_valid ? hold_data : mem_rdata;
`else
    assign accept  = 1'b1;
    assign wr_word = mem_rdata;
`endif

    assign aborting = ((state == RD_XFER || state == RD_DRAIN) && !rd_en) ||
                      ((state == WR_XFER || state == WR_DRAIN) && !wr_en);

    // cnt is the index of the word whose request is currently presented on the bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_done    <= 1'b0;
            wr_done    <= 1'b0;
            dram_re    <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef DRAM_STALL_EN
            hold_valid <= 1'b0;
            hold_data  <= '0;
`endif
        end else if (aborting) begin
            state   <= IDLE;
            dram_re <= 1'b0;
            dram_we <= 1'b0;
            mem_we  <= 1'b0;
`ifdef DRAM_STALL_EN
            hold_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rd_en) begin
                        state     <= RD_XFER;
                        dram_re   <= 1'b1;
                        dram_addr <= DRAM_AW'(RD_BASE);
                    end else if (wr_en) begin
                        state    <= WR_XFER;
                        mem_addr <= '0;
                    end
                end
                RD_XFER: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= MEM_AW'(cnt);
                        mem_wdata <= dram_rdata;
                        if (cnt == LAST_RD) begin
                            state   <= RD_DRAIN;
                            dram_re <= 1'b0;
                        end else begin
                            cnt       <= cnt + CNT_W'(1);
                            dram_addr <= DRAM_AW'(RD_BASE + int'(cnt) + 1);
                        end
                    end else begin
                        mem_we <= 1'b0;
                    end
                end
                RD_DRAIN: begin
                    mem_we  <= 1'b0;
                    rd_done <= 1'b1;
                    state   <= RD_DONE;
                end
                RD_DONE: begin
                    if (!rd_en) begin
                        rd_done <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WR_XFER: begin
                    if (accept) begin
                        dram_we    <= 1'b1;
                        dram_addr  <= DRAM_AW'(WR_BASE + int'(cnt));
                        dram_wdata <= wr_word;
`ifdef DRAM_STALL_EN
                        hold_valid <= 1'b0;
`endif
                        if (cnt == LAST_WR) begin
                            state <= WR_DRAIN;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            mem_addr <= MEM_AW'(cnt + CNT_W'(1));
                        end
                    end
`ifdef DRAM_STALL_EN
                    else if (!hold_valid) begin
                        hold_valid <= 1'b1;
                        hold_data  <= mem_rdata;
                    end
`endif
                end
                WR_DRAIN: begin
                    if (accept) begin
                        dram_we <= 1'b0;
                        wr_done <= 1'b1;
                        state   <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    if (!wr_en) begin
                        wr_done <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_xfer_ctrl.sv
// Scoreboard bench for dram_xfer_ctrl: small read/write transfers, priority, reset,
// abort and (with DRAM_STALL_EN) a DRAM backpressure scenario.
module tb_dram_xfer_ctrl;

    localparam int RD_N    = 4;
    localparam int RD_BASE = 8;
    localparam int WR_BASE = 100;
`ifdef DRAM_STALL_EN
    localparam int WR_N    = 3;
`else
    localparam int WR_N    = 2;
`endif

    typedef struct packed {
        int          cyc;
        logic [17:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        dramReady = 1'b1;
    logic        rd_done, wr_done, dram_re, dram_we, mem_we;
    logic [17:0] dram_addr;
    logic [7:0]  dram_wdata, dram_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic [7:0]  dramMem  [0:255];
    logic [7:0]  localMem [0:15];
    logic [7:0]  srcData  [0:3] = '{8'hAA, 8'h55, 8'h3C, 8'hE7};

    ev_t dramRdQ[$];
    ev_t memWrQ[$];
    ev_t dramWrQ[$];

    int cyc = 0;
    int checkCount = 0;
    int passCount = 0;

    dram_xfer_ctrl #(
        .DATA_W(8), .DRAM_AW(18), .MEM_AW(16),
        .RD_WORDS(RD_N), .WR_WORDS(WR_N), .RD_BASE(RD_BASE), .WR_BASE(WR_BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_en(rd_en),
        .wr_en(wr_en),
`ifdef DRAM_STALL_EN
        .dram_ready(dramReady),
`endif
        .rd_done(rd_done),
        .wr_done(wr_done),
        .dram_re(dram_re),
        .dram_we(dram_we),
        .dram_addr(dram_addr),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data follows the registered address within the same cycle.
    assign dram_rdata = dramMem[dram_addr[7:0]];
    assign mem_rdata  = localMem[mem_addr[3:0]];

    initial begin
        for (int i = 0; i < 256; i++) dramMem[i] = 8'h00;
        for (int i = 0; i < RD_N; i++) dramMem[RD_BASE + i] = srcData[i];
    end

    always @(posedge clk) begin
        if (mem_we) localMem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic checkEvent(input string name, input bit have, input ev_t exp, input ev_t act);
        checkCount++;
        if (!have)
            $display("[TB] FAIL %s: got cyc=%0d addr=%0d data=%h, expected no strobe",
                     name, act.cyc, act.addr, act.data);
        else if (act !== exp)
            $display("[TB] FAIL %s: got cyc=%0d addr=%0d data=%h, expected cyc=%0d addr=%0d data=%h",
                     name, act.cyc, act.addr, act.data, exp.cyc, exp.addr, exp.data);
        else passCount++;
    endtask

    // Monitor: every strobe the DUT presents is matched against the head of its queue.
    always @(negedge clk) begin
        ev_t act, exp;
        bit have;
        if (dram_re && dramReady) begin
            act = '{cyc: cyc, addr: dram_addr, data: 8'h00};
            have = dramRdQ.size() != 0;
            exp = '0;
            if (have) exp = dramRdQ.pop_front();
            checkEvent("dram_read", have, exp, act);
        end
        if (mem_we) begin
            act = '{cyc: cyc, addr: 18'(mem_addr), data: mem_wdata};
            have = memWrQ.size() != 0;
            exp = '0;
            if (have) exp = memWrQ.pop_front();
            checkEvent("mem_write", have, exp, act);
        end
        if (dram_we && dramReady) begin
            act = '{cyc: cyc, addr: dram_addr, data: dram_wdata};
            have = dramWrQ.size() != 0;
            exp = '0;
            if (have) exp = dramWrQ.pop_front();
            checkEvent("dram_write", have, exp, act);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rdEn, input logic wrEn, input logic rst);
        rd_en = rdEn;
        wr_en = wrEn;
        reset = rst;
    endtask

    // t0 is the cycle right after the edge that samples the request.
    task automatic pushRead(input int t0, input int n);
        for (int k = 0; k < n; k++) begin
            dramRdQ.push_back('{cyc: t0 + k, addr: 18'(RD_BASE + k), data: 8'h00});
            memWrQ.push_back('{cyc: t0 + k + 1, addr: 18'(k), data: srcData[k]});
        end
    endtask

    task automatic pushWrite(input int t0, input int n);
        for (int k = 0; k < n; k++)
            dramWrQ.push_back('{cyc: t0 + k + 1, addr: 18'(WR_BASE + k), data: srcData[k]});
    endtask

    task automatic runRead();
        int t0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        t0 = cyc + 1;
        pushRead(t0, RD_N);
        tick(RD_N + 1);
        checkOutput("rd_done before end", 64'(rd_done), 64'd0);
        tick(1);
        checkOutput("rd_done at end", 64'(rd_done), 64'd1);
        tick(2);
        checkOutput("rd_done held", 64'(rd_done), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("rd_done release", 64'(rd_done), 64'd0);
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({rd_done, wr_done, dram_re, dram_we, dram_addr, dram_wdata,
                    mem_we, mem_addr, mem_wdata});
    endfunction

    initial begin
        int t0, tw;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("reset outputs", allOutputs(), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(2);

        $display("[TB] plain read");
        runRead();
        tick(2);

        $display("[TB] plain write");
        applyStimulus(1'b0, 1'b1, 1'b1);
        t0 = cyc + 1;
        pushWrite(t0, WR_N);
        tick(WR_N + 1);
        checkOutput("wr_done before end", 64'(wr_done), 64'd0);
        tick(1);
        checkOutput("wr_done at end", 64'(wr_done), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("wr_done release", 64'(wr_done), 64'd0);
        tick(2);

        $display("[TB] both enables, read first");
        applyStimulus(1'b1, 1'b1, 1'b1);
        t0 = cyc + 1;
        pushRead(t0, RD_N);
        tick(RD_N + 2);
        checkOutput("rd_done with both", 64'(rd_done), 64'd1);
        checkOutput("wr_done during read", 64'(wr_done), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tw = cyc + 2;
        pushWrite(tw, WR_N);
        tick(1);
        checkOutput("rd_done drop", 64'(rd_done), 64'd0);
        tick(WR_N + 1);
        checkOutput("wr_done late before", 64'(wr_done), 64'd0);
        tick(1);
        checkOutput("wr_done late", 64'(wr_done), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(3);

        $display("[TB] reset during read");
        applyStimulus(1'b1, 1'b0, 1'b1);
        t0 = cyc + 1;
        pushRead(t0, 3);
        void'(memWrQ.pop_back());
        tick(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("mid-read reset outputs", allOutputs(), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        runRead();
        tick(2);

        $display("[TB] read abort");
        applyStimulus(1'b1, 1'b0, 1'b1);
        t0 = cyc + 1;
        pushRead(t0, 2);
        void'(memWrQ.pop_back());
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(6);
        checkOutput("rd_done after abort", 64'(rd_done), 64'd0);

`ifdef DRAM_STALL_EN
        $display("[TB] write with DRAM stall");
        applyStimulus(1'b0, 1'b1, 1'b1);
        t0 = cyc + 1;
        dramWrQ.push_back('{cyc: t0 + 1, addr: 18'(WR_BASE),     data: srcData[0]});
        dramWrQ.push_back('{cyc: t0 + 4, addr: 18'(WR_BASE + 1), data: srcData[1]});
        dramWrQ.push_back('{cyc: t0 + 5, addr: 18'(WR_BASE + 2), data: srcData[2]});
        tick(3);
        dramReady = 1'b0;
        tick(2);
        dramReady = 1'b1;
        tick(1);
        checkOutput("stall wr_done before", 64'(wr_done), 64'd0);
        tick(1);
        checkOutput("stall wr_done", 64'(wr_done), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("stall wr_done release", 64'(wr_done), 64'd0);
`endif

        tick(3);
        checkOutput("dram_read queue drained", 64'(dramRdQ.size()), 64'd0);
        checkOutput("mem_write queue drained", 64'(memWrQ.size()), 64'd0);
        checkOutput("dram_write queue drained", 64'(dramWrQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dram_xfer_ctrl.md
# dram_xfer_ctrl

DRAM-side responder to the master control FSM of the downsampling processor. On `rd_en` it copies the input image from external DRAM into the processor's local data memory and reports `rd_done`. On `wr_en` it copies the downsampled result from local memory back to DRAM and reports `wr_done`. It sits between the master control, the DRAM port and port B of the local data memory; it never touches the processor core.

## Interface
Parameters:
- `DATA_W`, 8: pixel/word width.
- `DRAM_AW`, 18: DRAM address width.
- `MEM_AW`, 16: local memory address width.
- `RD_WORDS`, 65536: words copied DRAM→local (256×256 image).
- `WR_WORDS`, 16384: words copied local→DRAM (128×128 result).
- `RD_BASE`, 0: DRAM source base address.
- `WR_BASE`, 65536: DRAM destination base address.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `rd_en`  in  1  level request from master: load image.
- `wr_en`  in  1  level request from master: store result.
- `rd_done`  out  1  level: load complete.
- `wr_done`  out  1  level: store complete.
- `dram_re`  out  1  DRAM read request.
- `dram_we`  out  1  DRAM write request.
- `dram_addr`  out  DRAM_AW  DRAM address.
- `dram_wdata`  out  DATA_W  DRAM write data.
- `dram_rdata`  in  DATA_W  DRAM read data, valid 1 cycle after accepted `dram_re`.
- `mem_we`  out  1  local memory write enable.
- `mem_addr`  out  MEM_AW  local memory address.
- `mem_wdata`  out  DATA_W  local memory write data.
- `mem_rdata`  in  DATA_W  local memory read data, valid 1 cycle after `mem_addr`.
- `dram_ready`  in  1  present only with `DRAM_STALL_EN`; see Configuration.

## Operation
- States: IDLE, RD_XFER, RD_DRAIN, RD_DONE, WR_XFER, WR_DRAIN, WR_DONE.
- IDLE: `rd_en` high → RD_XFER; otherwise `wr_en` high → WR_XFER. If both are high, read wins. The word counter `cnt` clears on exit. `cnt` width is clog2(max(RD_WORDS,WR_WORDS))+1.
- RD_XFER: for each accepted request, `dram_re`=1 and `dram_addr`=RD_BASE+cnt; `cnt` increments. On the following cycle, `mem_we`=1, `mem_addr`=previous cnt and `mem_wdata`=`dram_rdata`. After request RD_WORDS−1 is accepted → RD_DRAIN.
- RD_DRAIN: one cycle that performs the final local write → RD_DONE.
- RD_DONE: `rd_done`=1 and held while `rd_en`=1. When `rd_en`=0 is sampled → IDLE, and `rd_done` drops.
- WR_XFER: `mem_addr`=cnt is issued each advancing cycle. One cycle later, `dram_we`=1, `dram_addr`=WR_BASE+(cnt−1) and `dram_wdata`=`mem_rdata`. After address WR_WORDS−1 is issued → WR_DRAIN (final DRAM write) → WR_DONE.
- WR_DONE: same as RD_DONE, but for `wr_en`/`wr_done`.
- Abort: `rd_en` low in RD_XFER/RD_DRAIN, or `wr_en` low in WR_XFER/WR_DRAIN → IDLE next cycle. No done is raised and no further strobes are issued.
- `rd_en`/`wr_en` rising while the other transfer is busy: ignored until IDLE.
- Address arithmetic: base+cnt, truncated to DRAM_AW. Wrap-around is permitted and not flagged.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, `cnt`=0. All outputs are 0 (`rd_done`, `wr_done`, `dram_re`, `dram_we`, `mem_we`, all address and data buses) on the next cycle. This holds from any state, including mid-transfer.
- Without stalls: if `rd_en` is sampled at edge 0, `dram_re` is high on cycles 1..RD_WORDS, `mem_we` on cycles 2..RD_WORDS+1, and `rd_done` from cycle RD_WORDS+2.
- Write timing is the same: `dram_we` on cycles 2..WR_WORDS+1, and `wr_done` from cycle WR_WORDS+2.
- Done is a level, asserted at least 1 cycle. It deasserts the cycle after the enable is sampled low.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `DRAM_STALL_EN` defined: adds the `dram_ready` input.
  - A DRAM request is accepted only in a cycle where it is asserted and `dram_ready`=1.
  - While `dram_ready`=0, `dram_re`/`dram_we`, `dram_addr` and `dram_wdata` hold, and `cnt` does not advance.
  - In WR_XFER, a local word already read during a stall is captured in a 1-entry hold register, so no word is lost or duplicated.
- `DRAM_STALL_EN` undefined: no port; DRAM is treated as always ready, giving the fixed timing above.

## Test plan
- RD_WORDS=4, RD_BASE=8: assert `rd_en` → `dram_addr` 8,9,10,11 on cycles 1–4; `mem_we` at addresses 0–3 with the DRAM data on cycles 2–5; `rd_done`=1 on cycle 6; `rd_en` low → `rd_done`=0 one cycle later.
- WR_WORDS=2, WR_BASE=100: local memory holds {0xAA,0x55} → `dram_we` writes 100←0xAA and 101←0x55; `wr_done` on cycle 4.
- `rd_en` and `wr_en` high together in IDLE → read transfer runs and `wr_done` stays 0. After `rd_en` drops with `wr_en` still high → write transfer starts.
- `reset`=0 on cycle 3 of a read → all outputs 0 the next cycle, state IDLE. A new `rd_en` restarts from address RD_BASE.
- `rd_en` dropped on cycle 2 of a 4-word read → no `rd_done`, no strobes after cycle 3.
- `DRAM_STALL_EN`, WR_WORDS=3, `dram_ready` low for 2 cycles on the second word → DRAM receives exactly 3 writes, in order, with correct data, and `wr_done` is delayed 2 cycles.
